// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source result queue and round-robin common data bus arbiter

module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
endmodule

module cdb_arbiter #(
    parameter int RoB_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  rs_valid_in,
    output logic                  rs_ready_out,
    input  logic [RoB_WIDTH-1:0]  rs_rob_index_in,
    input  logic [31:0]           rs_value_in,
    input  logic [ADDR_WIDTH-1:0] rs_next_pc_in,
    input  logic                  lsb_valid_in,
    output logic                  lsb_ready_out,
    input  logic [RoB_WIDTH-1:0]  lsb_rob_index_in,
    input  logic [31:0]           lsb_value_in,
    output logic                  cdb_en_out,
    output logic                  cdb_src_out,
    output logic [RoB_WIDTH-1:0]  cdb_rob_index_out,
    output logic [31:0]           cdb_value_out,
    output logic [ADDR_WIDTH-1:0] cdb_next_pc_out
);
    localparam int RSW  = RoB_WIDTH + 32 + ADDR_WIDTH;
    localparam int LSBW = RoB_WIDTH + 32;

    logic            advance;
    logic            rs_full, rs_empty, lsb_full, lsb_empty;
    logic            rs_push, rs_pop, lsb_push, lsb_pop;
    logic [RSW-1:0]  rs_head;
    logic [LSBW-1:0] lsb_head;

    logic                  en_q, en_d;
    logic                  src_q, src_d;
    logic [RoB_WIDTH-1:0]  idx_q, idx_d;
    logic [31:0]           val_q, val_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  last_lsb_q, last_lsb_d;

    assign advance       = rdy_in & ~flush_in;
    assign rs_ready_out  = rst_in & ~rs_full;
    assign lsb_ready_out = rst_in & ~lsb_full;
    assign rs_push       = rs_valid_in & rs_ready_out & advance;
    assign lsb_push      = lsb_valid_in & lsb_ready_out & advance;

    // On a tie the source that did not win last time is served.
    assign rs_pop  = advance & ~rs_empty & (lsb_empty | last_lsb_q);
    assign lsb_pop = advance & ~lsb_empty & (rs_empty | ~last_lsb_q);

    cdb_fifo #(.WIDTH(RSW), .DEPTH(FIFO_DEPTH)) u_rs_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .clr_i   (flush_in),
        .push_i  (rs_push),
        .wdata_i ({rs_rob_index_in, rs_value_in, rs_next_pc_in}),
        .pop_i   (rs_pop),
        .rdata_o (rs_head),
        .full_o  (rs_full),
        .empty_o (rs_empty)
    );

    cdb_fifo #(.WIDTH(LSBW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .clr_i   (flush_in),
        .push_i  (lsb_push),
        .wdata_i ({lsb_rob_index_in, lsb_value_in}),
        .pop_i   (lsb_pop),
        .rdata_o (lsb_head),
        .full_o  (lsb_full),
        .empty_o (lsb_empty)
    );

    always_comb begin
        en_d       = 1'b0;
        src_d      = src_q;
        idx_d      = idx_q;
        val_d      = val_q;
        pc_d       = pc_q;
        last_lsb_d = last_lsb_q;
        if (flush_in) begin
            last_lsb_d = 1'b1;
        end else if (rs_pop) begin
            en_d       = 1'b1;
            src_d      = 1'b0;
            {idx_d, val_d, pc_d} = rs_head;
            last_lsb_d = 1'b0;
        end else if (lsb_pop) begin
            en_d       = 1'b1;
            src_d      = 1'b1;
            {idx_d, val_d} = lsb_head;
            pc_d       = '0;
            last_lsb_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            en_q       <= 1'b0;
            src_q      <= 1'b0;
            idx_q      <= '0;
            val_q      <= '0;
            pc_q       <= '0;
            last_lsb_q <= 1'b1;
        end else begin
            en_q       <= en_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            pc_q       <= pc_d;
            last_lsb_q <= last_lsb_d;
        end
    end

    assign cdb_en_out        = en_q;
    assign cdb_src_out       = src_q;
    assign cdb_rob_index_out = idx_q;
    assign cdb_value_out     = val_q;
    assign cdb_next_pc_out   = pc_q;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 8, the RoB index width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the next-PC width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, the per-source queue depth (power of two, >=2).
REQ-004 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rdy_in  input  1  global enable; low = pause.
REQ-007 SHALL have port flush_in  input  1  misprediction clear from RoB.
REQ-008 SHALL have port rs_valid_in  input  1  RS result offered.
REQ-009 SHALL have port rs_ready_out  output  1  RS queue can accept.
REQ-010 SHALL have ports rs_rob_index_in  input  RoB_WIDTH, rs_value_in  input  32, rs_next_pc_in  input  ADDR_WIDTH  RS result payload.
REQ-011 SHALL have port lsb_valid_in  input  1  LSB result offered.
REQ-012 SHALL have port lsb_ready_out  output  1  LSB queue can accept.
REQ-013 SHALL have ports lsb_rob_index_in  input  RoB_WIDTH, lsb_value_in  input  32  LSB result payload.
REQ-014 SHALL have port cdb_en_out  output  1  broadcast valid, one cycle per result.
REQ-015 SHALL have port cdb_src_out  output  1  0 = RS, 1 = LSB.
REQ-016 SHALL have ports cdb_rob_index_out  output  RoB_WIDTH, cdb_value_out  output  32, cdb_next_pc_out  output  ADDR_WIDTH  broadcast payload.

Function
REQ-017 SHALL hold one FIFO_DEPTH-entry FIFO per source; read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-018 SHALL drive x_ready_out = rst_in & (count_x < FIFO_DEPTH), from registered count only (no same-cycle pop credit).
REQ-019 SHALL push a source entry at a rising edge iff x_valid_in & x_ready_out & rdy_in & !flush_in; offers while not ready are ignored and the producer holds.
REQ-020 SHALL, at each edge with rdy_in=1 and flush_in=0, pop at most one entry total: if one FIFO non-empty pop it; if both non-empty pop the source not granted last.
REQ-021 SHALL register the popped entry into the cdb_*_out ports at that edge with cdb_en_out=1; cdb_en_out SHALL be 0 after any edge with no pop.
REQ-022 SHALL never bypass: an entry pushed at edge N is broadcast no earlier than edge N+1 (visible in the cycle after N+1).
REQ-023 SHALL allow push and pop of the same FIFO at one edge; count unchanged, payloads in order.
REQ-024 SHALL drive cdb_next_pc_out = 0 for LSB broadcasts.
REQ-025 SHALL update last-grant register on every pop; with both sources continuously busy, grants SHALL alternate RS, LSB, RS, ...
REQ-026 SHALL, at an edge with rdy_in=0 and flush_in=0, hold FIFOs, counts, pointers and last-grant, drive cdb_en_out to 0, hold payload outputs.
REQ-027 SHALL, at an edge with flush_in=1 (regardless of rdy_in), empty both FIFOs, drop same-cycle offers, set cdb_en_out to 0, set last-grant to LSB.
REQ-028 SHALL keep each FIFO in strict arrival order; no entry SHALL be broadcast twice or lost except by flush or reset.

Reset
REQ-029 SHALL, at an edge with rst_in=0, clear all FIFOs, counts and pointers, set last-grant to LSB (RS wins first tie), and drive all cdb_*_out to 0.
REQ-030 SHALL drive rs_ready_out and lsb_ready_out to 0 while rst_in=0; reset mid-operation SHALL discard all queued entries.

Verification
REQ-031 SHALL cover: RS offers {idx 5, val 0x11, pc 0x100} at edge 1 alone -> edge 2 cdb_en_out=1, src 0, idx 5, val 0x11, pc 0x100; edge 3 cdb_en_out=0.
REQ-032 SHALL cover: both offer at edge 1 (RS idx 1, LSB idx 2) after reset -> edge 2 broadcasts idx 1 src 0, edge 3 idx 2 src 1, pc 0.
REQ-033 SHALL cover: LSB offers 3 back-to-back while RS busy -> lsb_ready_out falls when count=2, all 3 LSB entries broadcast in order, none dropped.
REQ-034 SHALL cover: 2 entries queued per source, flush_in=1 for one edge -> cdb_en_out=0 next cycle, both ready_out=1, no further broadcasts.
REQ-035 SHALL cover: 1 queued entry, rdy_in=0 for 3 edges -> no broadcast, count held; first edge with rdy_in=1 broadcasts it exactly once.
REQ-036 SHALL cover: rst_in=0 with entries queued -> ready_outs 0 during reset, all outputs 0 after, no stale broadcast.
